// File: rtl/digilock_pkg.sv
// Shared DigiLock definitions: debounce FSM state encodings and default timing constants.
package digilock_pkg;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

  localparam int DEF_NUM_BTN      = 4;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_STABLE_TICKS = 2;
  localparam int DEF_REPEAT_DELAY = 8;
  localparam int DEF_REPEAT_RATE  = 2;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounced button channel: qualification FSM, auto-repeat counter and registered pulses.
module btn_debounce_ch
  import digilock_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic tick,
  input  logic s,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam bit REPEAT_EN = (REPEAT_DELAY != 0);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [RW-1:0] rcnt_r, rcnt_s;
  logic          rfirst_r, rfirst_s;
  logic          press_s, release_s, repeat_s;
  logic          cnt_done_s, rcnt_done_s;
  logic          level_r, press_r, release_r, repeat_r;

  // Terminal compares; the repeat target switches from the initial delay to the rate after the first repeat.
  always_comb begin
    cnt_done_s = (int'(cnt_r) + 32'sd1 == STABLE_TICKS);
    if (rfirst_r) begin
      rcnt_done_s = (int'(rcnt_r) + 32'sd1 == REPEAT_DELAY);
    end else begin
      rcnt_done_s = (int'(rcnt_r) + 32'sd1 == REPEAT_RATE);
    end
  end

  // Next-state logic; the FSM only advances in tick cycles.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    rcnt_s    = rcnt_r;
    rfirst_s  = rfirst_r;
    press_s   = 1'b0;
    release_s = 1'b0;
    repeat_s  = 1'b0;
    if (tick) begin
      case (state_r)
        ST_IDLE: begin
          if (s) begin
            state_s = ST_PRESS_CHK;
            cnt_s   = CNT_ONE;
          end else begin
            cnt_s   = '0;
          end
        end
        ST_PRESS_CHK: begin
          if (!s) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
          end else if (cnt_done_s) begin
            state_s  = ST_HELD;
            cnt_s    = '0;
            rcnt_s   = '0;
            rfirst_s = 1'b1;
            press_s  = 1'b1;
          end else begin
            cnt_s    = cnt_r + 1'b1;
          end
        end
        ST_HELD: begin
          if (!s) begin
            state_s = ST_RELEASE_CHK;
            cnt_s   = CNT_ONE;
          end else if (REPEAT_EN && rcnt_done_s) begin
            rcnt_s   = '0;
            rfirst_s = 1'b0;
            repeat_s = 1'b1;
          end else if (REPEAT_EN) begin
            rcnt_s   = rcnt_r + 1'b1;
          end else begin
            rcnt_s   = rcnt_r;
          end
        end
        ST_RELEASE_CHK: begin
          // A bounce back to 1 resumes HELD with the repeat schedule intact.
          if (s) begin
            state_s = ST_HELD;
            cnt_s   = '0;
          end else if (cnt_done_s) begin
            state_s   = ST_IDLE;
            cnt_s     = '0;
            release_s = 1'b1;
          end else begin
            cnt_s     = cnt_r + 1'b1;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          rcnt_s  = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      rcnt_r    <= '0;
      rfirst_r  <= 1'b0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      repeat_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      rcnt_r    <= rcnt_s;
      rfirst_r  <= rfirst_s;
      level_r   <= (state_s == ST_HELD) || (state_s == ST_RELEASE_CHK);
      press_r   <= press_s;
      release_r <= release_s;
      repeat_r  <= repeat_s;
    end
  end

  assign btn_level   = level_r;
  assign btn_press   = press_r;
  assign btn_release = release_r;
  assign btn_repeat  = repeat_r;

endmodule

// File: rtl/button_debouncer.sv
// Keypad debouncer top: slow_clk rising-edge tick, input synchronisers and one channel per button.
module button_debouncer
  import digilock_pkg::*;
#(
  parameter int NUM_BTN      = DEF_NUM_BTN,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               slow_clk,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  logic               slow_clk_q_r;
  logic               tick_s;
  logic [NUM_BTN-1:0] sync_r [SYNC_STAGES];
  logic [NUM_BTN-1:0] s_s;

  // slow_clk is plain data in this domain, so only its rising edge is turned into a tick.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      slow_clk_q_r <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      slow_clk_q_r <= slow_clk;
      sync_r[0]    <= btn_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign tick_s = slow_clk & ~slow_clk_q_r;
  assign s_s    = sync_r[SYNC_STAGES-1];

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_TICKS(STABLE_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .tick       (tick_s),
      .s          (s_s[g]),
      .btn_level  (btn_level[g]),
      .btn_press  (btn_press[g]),
      .btn_release(btn_release[g]),
      .btn_repeat (btn_repeat[g])
    );
  end

endmodule
